// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause codes
// and the counter-width calculation.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      ASSERT  = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_EXT  = 2'b01;
   localparam logic [1:0] CAUSE_SOFT = 2'b10;

   // One counter serves both the debounce hold and the inter-stage gap.
   function automatic int cnt_width(input int debounce_bits, input int stage_gap);
      int max_count;
      max_count = ((1 << debounce_bits) > stage_gap) ? (1 << debounce_bits) : stage_gap;
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Async-assert / sync-deassert reset synchroniser; rst_sync is high while the
// external reset is asserted and falls SYNC_STAGES edges after it is released.
module reset_seq_sync #(
   parameter int SYNC_STAGES = 4
) (
   input  logic clock,
   input  logic areset_n,
   output logic rst_sync
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
   end

   always_ff @(posedge clock or negedge areset_n) begin
      if (!areset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: debounces the external reset, releases reset[] in ascending order
// and replays the sequence on a soft request. Optional cause[] output: RESET_SEQ_CAUSE_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_RESETS    = 4,
   parameter int SYNC_STAGES   = 4,
   parameter int DEBOUNCE_BITS = 8,
   parameter int STAGE_GAP     = 16
) (
   input  logic                  clock,
   input  logic                  areset_n,
   input  logic                  soft_req,
   output logic                  soft_ack,
   output logic [NUM_RESETS-1:0] reset,
`ifdef RESET_SEQ_CAUSE_EN
   output logic [1:0]            cause,
`endif
   output logic                  ready
);

   localparam int CW = cnt_width(DEBOUNCE_BITS, STAGE_GAP);
   localparam int IW = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

   localparam logic [CW-1:0] DEB_LAST = CW'((1 << DEBOUNCE_BITS) - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RESETS - 1);

   logic                  rst_sync;
   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_RESETS-1:0] reset_q, reset_d;
   logic                  ready_q, ready_d;
   logic                  soft_ack_q, soft_ack_d;
`ifdef RESET_SEQ_CAUSE_EN
   logic [1:0]            cause_q, cause_d;
`endif

   reset_seq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock    (clock),
      .areset_n (areset_n),
      .rst_sync (rst_sync)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      reset_d    = reset_q;
      soft_ack_d = 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
      cause_d    = cause_q;
`endif

      case (state_q)
         HOLD: begin
            if (rst_sync) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d          = '0;
               reset_d[idx_q] = 1'b0;
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RUN: begin
            if (soft_req) begin
               state_d = ASSERT;
               idx_d   = IDX_LAST;
               cnt_d   = '0;
            end
         end

         ASSERT: begin
            // reset[0] is only set as the final step, so seeing it high means we're done.
            if (reset_q[0]) begin
               state_d    = HOLD;
               cnt_d      = '0;
               idx_d      = '0;
               soft_ack_d = 1'b1;
`ifdef RESET_SEQ_CAUSE_EN
               cause_d    = CAUSE_SOFT;
`endif
            end else if (cnt_q == GAP_LAST) begin
               cnt_d          = '0;
               reset_d[idx_q] = 1'b1;
               if (idx_q != '0) begin
                  idx_d = idx_q - 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            reset_d = '1;
         end
      endcase

      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clock or negedge areset_n) begin
      if (!areset_n) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         idx_q      <= '0;
         reset_q    <= '1;
         ready_q    <= 1'b0;
         soft_ack_q <= 1'b0;
`ifdef RESET_SEQ_CAUSE_EN
         cause_q    <= CAUSE_EXT;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         reset_q    <= reset_d;
         ready_q    <= ready_d;
         soft_ack_q <= soft_ack_d;
`ifdef RESET_SEQ_CAUSE_EN
         cause_q    <= cause_d;
`endif
      end
   end

   assign reset    = reset_q;
   assign ready    = ready_q;
   assign soft_ack = soft_ack_q;
`ifdef RESET_SEQ_CAUSE_EN
   assign cause    = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-output instance for the main sequences
// and a 1-output, gap-1 instance for the degenerate case.
`timescale 1ns/100ps
module tb_reset_sequencer;

   localparam int TN  = 3;
   localparam int TS  = 4;
   localparam int TD  = 3;
   localparam int TG  = 4;
   localparam int DEB = 1 << TD;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          areset_n = 1'b0;
   logic          soft_req = 1'b0;
   logic          soft_ack;
   logic [TN-1:0] reset_a;
   logic          ready;

   logic          areset_n_b = 1'b0;
   logic          soft_req_b = 1'b0;
   logic          soft_ack_b;
   logic [0:0]    reset_b;
   logic          ready_b;

`ifdef RESET_SEQ_CAUSE_EN
   logic [1:0] cause_a;
   logic [1:0] cause_b;
`endif

   reset_sequencer #(
      .NUM_RESETS(TN), .SYNC_STAGES(TS), .DEBOUNCE_BITS(TD), .STAGE_GAP(TG)
   ) dut_a (
      .clock    (clk),
      .areset_n (areset_n),
      .soft_req (soft_req),
      .soft_ack (soft_ack),
      .reset    (reset_a),
`ifdef RESET_SEQ_CAUSE_EN
      .cause    (cause_a),
`endif
      .ready    (ready)
   );

   reset_sequencer #(
      .NUM_RESETS(1), .SYNC_STAGES(TS), .DEBOUNCE_BITS(TD), .STAGE_GAP(1)
   ) dut_b (
      .clock    (clk),
      .areset_n (areset_n_b),
      .soft_req (soft_req_b),
      .soft_ack (soft_ack_b),
      .reset    (reset_b),
`ifdef RESET_SEQ_CAUSE_EN
      .cause    (cause_b),
`endif
      .ready    (ready_b)
   );

   int n_checks = 0;
   int n_err    = 0;
   int ecnt     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   // Edges up to and including base+TN*TG: reset[k] falls at base+(k+1)*TG.
   task automatic check_release(input int base, input bit ignore);
      logic [TN-1:0] exp_rst;
      while (ecnt < base + TN * TG) begin
         if (ignore)
            soft_req = (ecnt == base - 3) || (ecnt == base + 2) || (ecnt == base + TN * TG - 2);
         tick();
         for (int k = 0; k < TN; k++) exp_rst[k] = (ecnt < base + (k + 1) * TG);
         check($sformatf("rel_reset e%0d", ecnt), 32'(reset_a), 32'(exp_rst));
         check($sformatf("rel_ready e%0d", ecnt), 32'(ready), 32'(ecnt >= base + TN * TG));
         check($sformatf("rel_ack e%0d", ecnt), 32'(soft_ack), 32'd0);
      end
   endtask

   // Soft request raised now; returns base edge for the following release replay.
   task automatic check_soft(input bit sticky, output int rel_base);
      int t0;
      int rel;
      logic [TN-1:0] exp_rst;
      soft_req = 1'b1;
      t0 = ecnt;
      while (ecnt < t0 + TN * TG + 2) begin
         tick();
         rel = ecnt - t0;
         for (int k = 0; k < TN; k++) exp_rst[k] = (rel >= 1 + (TN - k) * TG);
         check($sformatf("soft_reset r%0d", rel), 32'(reset_a), 32'(exp_rst));
         check($sformatf("soft_ready r%0d", rel), 32'(ready), 32'd0);
         check($sformatf("soft_ack r%0d", rel), 32'(soft_ack), 32'(rel == TN * TG + 2));
      end
`ifdef RESET_SEQ_CAUSE_EN
      check("cause_soft", 32'(cause_a), 32'h2);
`endif
      if (!sticky) soft_req = 1'b0;
      rel_base = t0 + TN * TG + 2 + DEB;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rb;

      // Reset held
      repeat (5) tick();
      check("rst_reset", 32'(reset_a), 32'h7);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_ack", 32'(soft_ack), 32'd0);
      check("rst_b_reset", 32'(reset_b), 32'h1);
`ifdef RESET_SEQ_CAUSE_EN
      check("rst_cause", 32'(cause_a), 32'h1);
`endif

      // Power-up
      #4 areset_n = 1'b1;
      ecnt = 0;
      check_release(DEB + TS, 1'b0);

      // Soft reset and replay
      check_soft(1'b0, rb);
      check_release(rb, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
      check("cause_hold", 32'(cause_a), 32'h2);
`endif

      // Sticky request: ready high for one cycle between sequences
      check_soft(1'b1, rb);
      check_release(rb, 1'b0);
      check_soft(1'b0, rb);
      check_release(rb, 1'b0);
      tick();
      check("sticky_run_ready", 32'(ready), 32'd1);
      check("sticky_run_reset", 32'(reset_a), 32'd0);

      // Abort mid-release, then restart with ignored requests
      areset_n = 1'b0;
      tick();
      tick();
      #4 areset_n = 1'b1;
      ecnt = 0;
      while (ecnt < 17) tick();
      check("abort_pre_reset", 32'(reset_a), 32'h6);
      #2 areset_n = 1'b0;
      #0.5;
      check("abort_reset", 32'(reset_a), 32'h7);
      check("abort_ready", 32'(ready), 32'd0);
`ifdef RESET_SEQ_CAUSE_EN
      check("abort_cause", 32'(cause_a), 32'h1);
`endif
      #0.5 areset_n = 1'b1;
      ecnt = 0;
      check_release(DEB + TS, 1'b1);
      tick();
      check("ignore_ready_hold", 32'(ready), 32'd1);

      // Degenerate: one output, gap of one
      #4 areset_n_b = 1'b1;
      ecnt = 0;
      while (ecnt < 14) begin
         tick();
         check($sformatf("b_reset e%0d", ecnt), 32'(reset_b), 32'(ecnt < 13));
         check($sformatf("b_ready e%0d", ecnt), 32'(ready_b), 32'(ecnt >= 13));
      end
      soft_req_b = 1'b1;
      tick();
      check("b_assert_ready", 32'(ready_b), 32'd0);
      check("b_assert_reset", 32'(reset_b), 32'd0);
      tick();
      check("b_set_reset", 32'(reset_b), 32'd1);
      check("b_set_ack", 32'(soft_ack_b), 32'd0);
      tick();
      check("b_ack", 32'(soft_ack_b), 32'd1);
      soft_req_b = 1'b0;
      tick();
      check("b_ack_drop", 32'(soft_ack_b), 32'd0);
      while (ecnt < 25) tick();
      check("b_replay_hold", 32'(reset_b), 32'd1);
      tick();
      check("b_replay_reset", 32'(reset_b), 32'd0);
      check("b_replay_ready", 32'(ready_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised single-clock reset sequencer for N downstream reset domains in one clock domain.
- Synchronises and debounces an external active-low async reset, then releases NUM_RESETS outputs in ascending order with a programmable gap.
- Supports a soft-reset request that re-asserts outputs in descending order, then replays the full release sequence.
- Sits between the board/PLL reset logic and core, uncore and peripheral resets.

Parameters:
- NUM_RESETS, 4, number of sequenced reset outputs (>=1)
- SYNC_STAGES, 4, synchroniser depth for areset_n deassertion (>=2)
- DEBOUNCE_BITS, 8, hold time of 2^DEBOUNCE_BITS cycles after synchronised release (>=1)
- STAGE_GAP, 16, cycles between successive output transitions (>=1)

Ports:
- clock  in  1  sole clock
- areset_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronised internally
- soft_req  in  1  level soft-reset request; sampled only in RUN
- soft_ack  out  1  one-cycle pulse when all outputs are asserted by a soft request
- reset  out  NUM_RESETS  active-high resets; bit 0 released first, asserted last
- ready  out  1  high only in RUN (all resets released)

Behaviour:
- areset_n low, asynchronous: reset = all ones, ready = 0, soft_ack = 0, state = HOLD, counters and index = 0, rst_sync = 1.
- rst_sync: async set by areset_n low. Shifts to 0 through SYNC_STAGES flops.
- Timing: edge 1 = first rising edge sampling areset_n high.
  - rst_sync falls after edge SYNC_STAGES.
- HOLD:
  - While rst_sync = 1, the counter is held at 0.
  - Otherwise, count 2^DEBOUNCE_BITS cycles, then go to RELEASE with idx = 0 and gap counter = 0.
- RELEASE:
  - Gap counter counts STAGE_GAP cycles.
  - On terminal count, clear reset[idx] and reload the gap counter.
  - If idx = NUM_RESETS-1, go to RUN; else idx++.
  - reset[k] falls at edge SYNC_STAGES + 2^DEBOUNCE_BITS + (k+1)*STAGE_GAP.
- RUN:
  - ready = 1.
  - When soft_req = 1, go to ASSERT with idx = NUM_RESETS-1. ready falls on that same edge.
- ASSERT:
  - Every STAGE_GAP cycles, set reset[idx], in order idx = NUM_RESETS-1 down to 0.
  - After setting reset[0], pulse soft_ack for 1 cycle on the next edge and enter HOLD. The full debounce is counted because rst_sync is already 0.
  - RELEASE then repeats as on power-up.
- soft_req is ignored outside RUN. If it is still high on the return to RUN, a new sequence starts immediately. The requester must drop it on soft_ack.
- areset_n asserted in any state aborts immediately to the reset values; no partial sequence is retained.
- Counter width is $clog2(max(2^DEBOUNCE_BITS, STAGE_GAP)+1). There is no wrap: each counter is cleared at terminal count.
- NUM_RESETS = 1: RELEASE goes straight to RUN and ASSERT goes straight to HOLD after one gap.
- reset and ready are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: RESET_SEQ_CAUSE_EN.
- When defined, adds output cause[1:0].
  - Reset value 2'b01 (external/power-on).
  - Loaded with 2'b10 (soft) on the soft_ack edge.
  - Loaded with 2'b01 again only by areset_n.
  - Holds otherwise.
- When undefined, the port and register are absent and behaviour is otherwise identical.

Decomposition:
- Package reset_seq_pkg:
  - state enum: HOLD, RELEASE, RUN, ASSERT
  - cause encodings: CAUSE_EXT = 2'b01, CAUSE_SOFT = 2'b10
  - counter-width helper function
- Sub-module reset_seq_sync: SYNC_STAGES-deep async-assert, sync-deassert synchroniser, output rst_sync.
- The FSM and counters stay in reset_sequencer.

Test Plan (bench params NUM_RESETS=3, SYNC_STAGES=4, DEBOUNCE_BITS=3, STAGE_GAP=4):
- Power-up: areset_n low 5 cycles, then high -> reset = 3'b111 until edge 15.
  - reset[0] falls at edge 16, reset[1] at 20, reset[2] at 24.
  - ready rises at edge 24.
- Soft reset: in RUN, soft_req = 1 -> reset[2] set 4 cycles after entering ASSERT, reset[1] 4 later, reset[0] 4 later.
  - soft_ack pulses 1 cycle on the next edge.
  - After 8 HOLD cycles, the release replays as in power-up; cause = 2'b10 if enabled.
- Abort: areset_n pulsed low for 1 ns mid-RELEASE, with reset = 3'b110 -> reset = 3'b111 and ready = 0 immediately; the sequence restarts with power-up timing.
- Sticky request: soft_req held high through soft_ack -> a second ASSERT starts on the first RUN cycle; ready is high for exactly 1 cycle.
- Ignored request: soft_req pulsed during HOLD and RELEASE only -> no ASSERT; ready rises at edge 24 unchanged.
- Degenerate: NUM_RESETS=1, STAGE_GAP=1 -> reset[0] falls at edge 13.
  - A soft request asserts reset[0] after 1 cycle; soft_ack follows 1 cycle later.
